// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD sequencer.
// Bit positions mirror the LSU's LCD output register and status word.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } lcd_state_e;

    localparam int unsigned LCD_ON_BIT    = 31;
    localparam int unsigned LCD_EN_BIT    = 10;
    localparam int unsigned LCD_RS_BIT    = 9;
    localparam int unsigned LCD_RW_BIT    = 8;
    localparam int unsigned LCD_DATA_MSB  = 7;
    localparam int unsigned LCD_DATA_LSB  = 0;

    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_OVR_BIT  = 1;

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait
    localparam logic [7:0] CLR_HOME_MASK = 8'hFC;

    function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
        return !rs && ((data & CLR_HOME_MASK) == 8'h00) && (data != 8'h00);
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed phase of the LCD bus cycle.
// Load takes priority; the count parks at zero and never wraps.
module lcd_timer #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Sequences one LSU byte write into a timed RS/DATA/EN cycle on an HD44780 bus,
// then waits out the controller execution time before accepting the next byte.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP_CYC = 2,
    parameter int unsigned T_EN_CYC    = 25,
    parameter int unsigned T_HOLD_CYC  = 2,
    parameter int unsigned T_EXEC_CYC  = 2000,
    parameter int unsigned T_CLEAR_CYC = 82000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        req_rs_i,
    input  logic [7:0]  req_data_i,
    input  logic        lcd_on_i,
    input  logic        clr_ovr_i,
    output logic        req_ready_o,
    output logic [31:0] status_o,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o
);

    localparam int unsigned CW = (T_CLEAR_CYC > 1) ? $clog2(T_CLEAR_CYC) : 1;

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(T_EN_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD_CYC - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC_CYC - 1);
    localparam logic [CW-1:0] LD_CLEAR = CW'(T_CLEAR_CYC - 1);

    lcd_state_e  state_q;
    logic        rs_q;
    logic [7:0]  data_q;
    logic        en_q;
    logic        ready_q;
    logic        ovr_q;
    logic        on_q;

    logic          tmr_load;
    logic          tmr_done;
    logic [CW-1:0] tmr_val;

    // Timer is reloaded on the edge that leaves each phase with the next phase's length
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = LD_SETUP;
        case (state_q)
            IDLE: begin
                tmr_load = req_valid_i;
                tmr_val  = LD_SETUP;
            end
            SETUP: begin
                tmr_load = tmr_done;
                tmr_val  = LD_EN;
            end
            PULSE: begin
                tmr_load = tmr_done;
                tmr_val  = LD_HOLD;
            end
            HOLD: begin
                tmr_load = tmr_done;
                tmr_val  = is_clear_home(rs_q, data_q) ? LD_CLEAR : LD_EXEC;
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    lcd_timer #(
        .CW (CW)
    ) u_timer (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rs_q    <= 1'b0;
            data_q  <= '0;
            en_q    <= 1'b0;
            ready_q <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            // A dropped strobe outranks a simultaneous clear
            if (req_valid_i && state_q != IDLE) begin
                ovr_q <= 1'b1;
            end else if (clr_ovr_i) begin
                ovr_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        rs_q    <= req_rs_i;
                        data_q  <= req_data_i;
                        ready_q <= 1'b0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (tmr_done) begin
                        en_q    <= 1'b1;
                        state_q <= PULSE;
                    end
                end
                PULSE: begin
                    if (tmr_done) begin
                        en_q    <= 1'b0;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (tmr_done) begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (tmr_done) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            on_q <= 1'b0;
        end else begin
            on_q <= lcd_on_i;
        end
    end

    always_comb begin
        status_o                = '0;
        status_o[STAT_BUSY_BIT] = ~ready_q;
        status_o[STAT_OVR_BIT]  = ovr_q;
    end

    assign req_ready_o = ready_q;
    assign lcd_on_o    = on_q;
    assign lcd_en_o    = en_q;
    assign lcd_rs_o    = rs_q;
    assign lcd_rw_o    = 1'b0;
    assign lcd_data_o  = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: stimulus queues the expected bus cycle,
// a negedge monitor measures each busy window and checks it on completion.
module tb_lcd_ctrl;

    localparam int unsigned TS = 2;
    localparam int unsigned TE = 3;
    localparam int unsigned TH = 1;
    localparam int unsigned TX = 5;
    localparam int unsigned TC = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_rs;
    logic [7:0]  req_data;
    logic        lcd_on;
    logic        clr_ovr;
    logic        req_ready;
    logic [31:0] status;
    logic        lcd_on_o;
    logic        lcd_en;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_SETUP_CYC (TS),
        .T_EN_CYC    (TE),
        .T_HOLD_CYC  (TH),
        .T_EXEC_CYC  (TX),
        .T_CLEAR_CYC (TC)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_rs_i    (req_rs),
        .req_data_i  (req_data),
        .lcd_on_i    (lcd_on),
        .clr_ovr_i   (clr_ovr),
        .req_ready_o (req_ready),
        .status_o    (status),
        .lcd_on_o    (lcd_on_o),
        .lcd_en_o    (lcd_en),
        .lcd_rs_o    (lcd_rs),
        .lcd_rw_o    (lcd_rw),
        .lcd_data_o  (lcd_data)
    );

    typedef struct {
        logic        rs;
        logic [7:0]  data;
        int unsigned exec;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        vec [0:5];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Monitor state
    logic        tracking = 1'b0;
    int unsigned cyc, en_rise, en_fall, en_cnt, spurious = 0;
    logic        rs0, changed, busy_bad;
    logic [7:0]  data0;
    exp_t        e;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            tracking = 1'b0;
            if (lcd_en !== 1'b0) spurious++;
        end else if (!tracking) begin
            if (req_ready === 1'b0) begin
                tracking = 1'b1;
                cyc      = 1;
                rs0      = lcd_rs;
                data0    = lcd_data;
                changed  = 1'b0;
                en_cnt   = lcd_en ? 1 : 0;
                en_rise  = lcd_en ? 1 : 0;
                en_fall  = 0;
                busy_bad = (status[0] !== 1'b1);
            end else if (lcd_en !== 1'b0) begin
                spurious++;
            end
        end else begin
            cyc++;
            if (lcd_rs !== rs0 || lcd_data !== data0) changed = 1'b1;
            if (lcd_en === 1'b1) begin
                en_cnt++;
                if (en_rise == 0) en_rise = cyc;
            end else if (en_rise != 0 && en_fall == 0) begin
                en_fall = cyc;
            end
            if (req_ready !== 1'b1 && status[0] !== 1'b1) busy_bad = 1'b1;
            if (req_ready === 1'b1) begin
                tracking = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_tx", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_rs", {31'b0, rs0}, {31'b0, e.rs});
                    check("tx_data", {24'b0, data0}, {24'b0, e.data});
                    check("tx_bus_stable", {31'b0, changed}, 0);
                    check("tx_en_rise_cycle", en_rise, TS + 1);
                    check("tx_en_fall_cycle", en_fall, TS + TE + 1);
                    check("tx_en_width", en_cnt, TE);
                    check("tx_ready_cycle", cyc, TS + TE + TH + e.exec + 1);
                    check("tx_busy_bit", {31'b0, busy_bad}, 0);
                end
            end
        end
    end

    // Called at a negedge; the strobe is sampled on the following rising edge
    task automatic send(input logic rs, input logic [7:0] d);
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int unsigned budget);
        int unsigned n = 0;
        while (req_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) check(name, {31'b0, req_ready}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] on_pat;
    logic        prev_on;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_data  = 8'h00;
        lcd_on    = 1'b0;
        clr_ovr   = 1'b0;
        vec[0] = '{1'b1, 8'h41, TX};
        vec[1] = '{1'b0, 8'h01, TC};
        vec[2] = '{1'b0, 8'h80, TX};
        vec[3] = '{1'b0, 8'h02, TC};
        vec[4] = '{1'b0, 8'h03, TC};
        vec[5] = '{1'b0, 8'h04, TX};

        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 1);
        check("rst_en", {31'b0, lcd_en}, 0);
        check("rst_rs", {31'b0, lcd_rs}, 0);
        check("rst_rw", {31'b0, lcd_rw}, 0);
        check("rst_data", {24'b0, lcd_data}, 0);
        check("rst_on", {31'b0, lcd_on_o}, 0);
        check("rst_status", status, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Data write plus clear/home and ordinary commands
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vec[i]);
            send(vec[i].rs, vec[i].data);
            wait_ready("vec_ready_timeout", 40);
        end
        @(negedge clk);

        // Dropped strobe during a write, overrun clear and set-over-clear priority
        exp_q.push_back('{1'b1, 8'h41, TX});
        send(1'b1, 8'h41);
        repeat (2) @(negedge clk);
        send(1'b0, 8'h42);
        check("ovr_set_status", status, 32'h3);
        check("ovr_data_kept", {24'b0, lcd_data}, 32'h41);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        check("ovr_clr_status", status, 32'h1);
        clr_ovr = 1'b1;
        send(1'b1, 8'h44);
        clr_ovr = 1'b0;
        check("ovr_set_wins", status, 32'h3);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        check("ovr_clr_again", status, 32'h1);
        wait_ready("ovr_ready_timeout", 40);
        check("ovr_idle_status", status, 32'h0);
        @(negedge clk);

        // Asynchronous reset in the middle of the EN pulse
        send(1'b1, 8'h55);
        repeat (2) @(negedge clk);
        check("pre_rst_en", {31'b0, lcd_en}, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_en", {31'b0, lcd_en}, 0);
        check("midrst_ready", {31'b0, req_ready}, 1);
        check("midrst_status", status, 0);
        check("midrst_data", {24'b0, lcd_data}, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back('{1'b0, 8'h38, TX});
        send(1'b0, 8'h38);
        wait_ready("postrst_ready_timeout", 40);
        @(negedge clk);

        // Back-to-back: second strobe in the first idle cycle
        exp_q.push_back('{1'b1, 8'h41, TX});
        send(1'b1, 8'h41);
        wait_ready("b2b_first_timeout", 40);
        exp_q.push_back('{1'b1, 8'h43, TX});
        send(1'b1, 8'h43);
        check("b2b_accepted", {31'b0, req_ready}, 0);
        check("b2b_no_overrun", status, 32'h1);
        wait_ready("b2b_second_timeout", 40);
        @(negedge clk);

        // lcd_on follows with one register of delay through every phase
        on_pat = 16'b0010_1101_1001_0110;
        exp_q.push_back('{1'b1, 8'h5A, TX});
        send(1'b1, 8'h5A);
        for (int i = 0; i < 14; i++) begin
            prev_on = lcd_on;
            lcd_on  = on_pat[i];
            #1 check("on_not_early", {31'b0, lcd_on_o}, {31'b0, prev_on});
            @(negedge clk);
            check("on_follow", {31'b0, lcd_on_o}, {31'b0, on_pat[i]});
        end
        lcd_on = 1'b0;
        wait_ready("on_ready_timeout", 40);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("no_spurious_en", spurious, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
Memory-mapped HD44780-style character-LCD sequencer, directly downstream of the load/store unit's LCD output register. The LSU presents one byte command/data write per store. This block turns it into a correctly timed RS/RW/DATA/EN bus cycle, then waits out the controller's execution time. Software no longer bit-bangs EN. A busy/overrun status word goes back to the LSU load path.

Parameters:
T_SETUP_CYC, 2, cycles RS/DATA stable before EN rises (≥1)
T_EN_CYC, 25, cycles EN held high (≥1; 500 ns at 50 MHz)
T_HOLD_CYC, 2, cycles RS/DATA held after EN falls (≥1)
T_EXEC_CYC, 2000, post-pulse wait for normal commands/data (≥1; 40 µs)
T_CLEAR_CYC, 82000, post-pulse wait for clear/home commands (≥T_EXEC_CYC; 1.64 ms)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  one-cycle write strobe from LSU
req_rs_i  in  1  0 = command, 1 = data
req_data_i  in  8  byte to send
lcd_on_i  in  1  LCD power/backlight enable from LSU register bit 31
clr_ovr_i  in  1  clears sticky overrun flag
req_ready_o  out  1  block idle, next strobe will be accepted
status_o  out  32  {30'b0, overrun, busy} for LSU read-back
lcd_on_o  out  1  registered lcd_on_i
lcd_en_o  out  1  LCD enable strobe
lcd_rs_o  out  1  LCD register select
lcd_rw_o  out  1  LCD read/write, tied to write (0)
lcd_data_o  out  8  LCD data bus

Behaviour:
- Clock is clk_i. Reset is rst_ni, asynchronous and active-low.
- Reset values:
  - FSM=IDLE, req_ready_o=1.
  - lcd_en_o=0, lcd_rs_o=0, lcd_rw_o=0, lcd_data_o=0, lcd_on_o=0.
  - overrun=0, busy=0, counter=0.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately (asynchronously).
  - An in-flight command is lost.
  - EN must never glitch high during or after reset.
- Accept rule: req_valid_i && state==IDLE at a rising edge.
  - Capture rs/data into registers that drive lcd_rs_o/lcd_data_o.
  - Enter SETUP.
  - busy=1 and req_ready_o=0 from the next cycle.
- FSM (down-counter loaded with N-1; a state exits when the counter reads 0):
  - IDLE: EN=0; outputs hold the last byte. Go to SETUP on accept.
  - SETUP: T_SETUP_CYC cycles, EN=0 → PULSE.
  - PULSE: T_EN_CYC cycles, EN=1 (registered output) → HOLD.
  - HOLD: T_HOLD_CYC cycles, EN=0, RS/DATA unchanged → EXEC.
  - EXEC: T_CLEAR_CYC cycles if rs==0 and data[7:2]==0 and data!=0 (0x01/0x02/0x03); otherwise T_EXEC_CYC → IDLE.
- Busy time from accept edge to req_ready_o=1: T_SETUP+T_EN+T_HOLD+T_EXEC cycles (T_CLEAR for clear/home).
- Back-to-back: a strobe in the first IDLE cycle is accepted. There is no mandatory idle gap.
- Request while not IDLE:
  - The request is dropped. There is no queue.
  - overrun sets on the next edge and stays set.
  - LCD outputs are unaffected.
- Overrun clearing:
  - clr_ovr_i clears overrun on the next edge.
  - If clr_ovr_i and a dropped request occur in the same cycle, set wins.
- lcd_on_o = lcd_on_i delayed one register stage, independent of FSM state.
- Counter width: $clog2(T_CLEAR_CYC) bits. No wrap-around: it is only ever loaded and decremented to 0.
- lcd_rw_o is constant 0. Busy-flag reads from the LCD are not supported.

Decomposition:
- Package lcd_pkg:
  - state enum {IDLE, SETUP, PULSE, HOLD, EXEC}.
  - LCD register bit positions: ON=31, EN=10, RS=9, RW=8, DATA=7:0.
  - status bit positions: BUSY=0, OVR=1.
  - clear/home opcode mask.
- Sub-module lcd_timer: loadable down-counter.
  - Inputs: load, load value.
  - Output: done (count==0).
  - One instance, shared by all timed states.

Test Plan (T_SETUP=2, T_EN=3, T_HOLD=1, T_EXEC=5, T_CLEAR=20):
1. Data write: rs=1, data=0x41, accepted at edge 0.
   - Expect lcd_rs_o=1 and lcd_data_o=0x41 from cycle 1.
   - Expect lcd_en_o=1 exactly in cycles 3–5.
   - Expect req_ready_o=1 at cycle 12 (11 busy cycles); status_o=0x1 while busy.
2. Clear command: rs=0, data=0x01.
   - Expect EN pulse in cycles 3–5, EXEC lasting 20 cycles, ready at cycle 27.
   - Repeat with data=0x80: ready at cycle 12.
3. Strobe 0x42 at cycle 4 during an active write.
   - Expect lcd_data_o stays 0x41 and status_o=0x3.
   - After pulsing clr_ovr_i: status_o=0x1 while still busy, 0x0 when idle.
4. Deassert rst_ni mid-PULSE (cycle 4).
   - Expect lcd_en_o=0 immediately, req_ready_o=1, status_o=0, lcd_data_o=0.
   - After release, a new write completes with normal timing.
5. Back-to-back: second strobe (rs=1, 0x43) in the first IDLE cycle after a write.
   - Expect it accepted, overrun=0, second EN pulse with identical 2/3/1 spacing.
6. Toggle lcd_on_i 0→1→0 across all FSM states.
   - Expect lcd_on_o to follow with exactly one cycle delay.
   - Expect no effect on EN/RS/DATA.
